trap_filter_sequencer: RTL and testbench
========================================

Name: trap_filter_sequencer

Overview:
Controls the trapezoidal shaping filter and applies runtime shaping parameters (k, l, M) to it. It loads a new configuration through a valid/ready handshake, then runs a clear/settle sequence so that no output from a mixed configuration is ever marked valid. In the RUN state it qualifies the shaped output with a threshold and reports one peak amplitude and pulse width per pulse. It sits between the register/config interface and the filter output consumer.

Parameters:
MAX_DEPTH, 64, upper limit on k+l; sets the filter delay-line length
PIPE_LAT, 6, register stages from filter input to filter output
FLUSH_CYCLES, 4, number of cycles the filter clear is held after a config change
DEF_K, 8, k value after reset
DEF_L, 16, l value after reset
DEF_M, 32, M value after reset
CW, $clog2(MAX_DEPTH+1), width of k and l

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; deasserting it forces IDLE
cfg_valid  in  1  config offer
cfg_ready  out  1  config can be accepted
cfg_k  in  CW  new k
cfg_l  in  CW  new l
cfg_m  in  16  new M
cfg_err  out  1  one-cycle pulse when an offered config is rejected
thr  in  SIZE_FILTER_DATA  signed pulse threshold
filt_clear  out  1  synchronous clear to the filter
filt_en  out  1  filter clock enable
act_k  out  CW  active k driven to the filter
act_l  out  CW  active l driven to the filter
act_m  out  16  active M driven to the filter
filt_data  in  SIZE_FILTER_DATA  signed filter output
data_valid  out  1  filter output is settled
peak_valid  out  1  one-cycle peak report strobe
peak_value  out  SIZE_FILTER_DATA  maximum of the pulse
peak_width  out  16  number of cycles the pulse stayed above thr (saturating)

Behaviour:
- Reset values:
  - state = IDLE
  - act_k/l/m = DEF_K/L/M
  - filt_clear = 1, filt_en = 0
  - cfg_ready = 1, cfg_err = 0
  - data_valid = 0
  - peak_valid = 0, peak_value = 0, peak_width = 0
- A config transfer occurs on the clk edge where cfg_valid && cfg_ready.
  - cfg_ready = 1 in IDLE and in RUN_WAIT. It is 0 in FLUSH, SETTLE and RUN_PULSE.
- A config is valid only when k ≥ 1, l ≥ k and k+l ≤ MAX_DEPTH.
  - Invalid config: cfg_err = 1 for exactly the next cycle. Active values and state are unchanged.
  - Valid config: act_* update on the next cycle.
    - In IDLE the state stays IDLE.
    - In RUN_WAIT the state goes to FLUSH.
- State machine:
  - IDLE: filt_clear = 1, filt_en = 0. Goes to FLUSH when enable = 1.
  - FLUSH: filt_clear = 1, filt_en = 1. Lasts FLUSH_CYCLES cycles, then SETTLE.
  - SETTLE: filt_clear = 0, filt_en = 1. Counter runs act_k+act_l+PIPE_LAT cycles, then RUN_WAIT.
  - RUN_WAIT: data_valid = 1.
    - If filt_data > thr (signed compare): go to RUN_PULSE, max ← filt_data, width ← 1.
  - RUN_PULSE: data_valid = 1.
    - While filt_data > thr: max ← max(max, filt_data); width increments and saturates at 0xFFFF.
    - First cycle with filt_data ≤ thr: peak_valid = 1 for one cycle with the captured max/width, then RUN_WAIT.
- data_valid is 0 in every state except RUN_WAIT and RUN_PULSE.
- enable = 0 in any state: IDLE on the next cycle. An open pulse is discarded (no peak_valid).
- A config offered in the same cycle that enable falls:
  - Accepted only when cfg_ready is 1 in that cycle.
  - act_* update normally; the state still goes to IDLE.
- Reset asserted mid-sequence: all reset values apply on the next edge, whatever the state.
- peak_value and peak_width hold their values between strobes.

Optional Feature:
PILEUP_REJECT_EN
- Defined: if width reaches 2*(act_k+act_l) while in RUN_PULSE, the pulse is marked pileup.
  - On the falling edge no peak_valid is generated.
  - Output pileup_cnt (16 bits, saturating, reset 0) increments.
- Not defined: every pulse is reported and the pileup_cnt port is absent.

Decomposition:
- package_settings provides SIZE_FILTER_DATA.
- A new package, trap_seq_pkg, holds:
  - the state enum type (IDLE, FLUSH, SETTLE, RUN_WAIT, RUN_PULSE)
  - DEF_K/L/M
  - PIPE_LAT
- One sub-module, trap_peak_detector, holds the RUN_WAIT/RUN_PULSE compare, max/width capture and pileup logic. It has an arm input and an abort input.

Test Plan:
1. Reset, then enable = 1 with default config → filt_clear high for 4 cycles, then data_valid = 0 for 8+16+6 = 30 cycles, then data_valid = 1.
2. In RUN_WAIT, offer k = 4, l = 8, M = 100 → accepted in one cycle; act_* = 4/8/100 next cycle; FLUSH for 4 cycles; data_valid returns after 4+8+6 = 18 cycles.
3. Offer k = 10, l = 5 → cfg_err pulses once; act_* unchanged; data_valid stays 1.
4. thr = 50, filt_data sequence 0, 60, 120, 90, 40 → peak_valid once, on the cycle with 40, with peak_value = 120 and peak_width = 3.
5. Drop enable while filt_data = 200 is above threshold → no peak_valid; IDLE next cycle; filt_clear = 1.
6. With PILEUP_REJECT_EN, k = 4, l = 8, filt_data above thr for 30 cycles → no peak_valid; pileup_cnt = 1.

Source files
------------

// File: rtl/package_settings.sv
// Shared system settings: data width of the trapezoidal filter output.
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/trap_seq_pkg.sv
// Sequencer state encoding, reset-time shaping defaults and config validity rule.
package trap_seq_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, SETTLE, RUN_WAIT, RUN_PULSE} seq_state_e;

  localparam int DEF_K    = 8;
  localparam int DEF_L    = 16;
  localparam int DEF_M    = 32;
  localparam int PIPE_LAT = 6;

  function automatic logic cfg_is_valid(input int k, input int l, input int max_depth);
    return (k >= 1) && (l >= k) && (k + l <= max_depth);
  endfunction
endpackage

// File: rtl/trap_filter_sequencer_if.sv
// Config handshake bus between the register block (master) and the sequencer (slave).
interface trap_filter_sequencer_if #(parameter int CW = 7);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_k;
  logic [CW-1:0] cfg_l;
  logic [15:0]   cfg_m;
  logic          cfg_err;

  modport master(output cfg_valid, cfg_k, cfg_l, cfg_m, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_k, cfg_l, cfg_m, output cfg_ready, cfg_err);
endinterface

// File: rtl/trap_peak_detector.sv
// Threshold qualifier: tracks max/width of each pulse and strobes one report per pulse.
// Optional PILEUP_REJECT_EN drops over-long pulses and counts them instead.
module trap_peak_detector import package_settings::*; #(
  parameter int DW = SIZE_FILTER_DATA
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 track,
  input  logic                 abort,
  input  logic signed [DW-1:0] data,
  input  logic signed [DW-1:0] thr,
`ifdef PILEUP_REJECT_EN
  input  logic [15:0]          pileup_lim,
  output logic [15:0]          pileup_cnt,
`endif
  output logic                 above,
  output logic                 peak_valid,
  output logic signed [DW-1:0] peak_value,
  output logic [15:0]          peak_width
);
  logic signed [DW-1:0] max_q, held_v;
  logic [15:0]          width_q, held_w;
  logic                 fall, pileup;

  assign above = data > thr;
  assign fall  = track && !above && !abort;
`ifdef PILEUP_REJECT_EN
  assign pileup = width_q >= pileup_lim;
`else
  assign pileup = 1'b0;
`endif
  assign peak_valid = fall && !pileup;
  // Report bypasses the hold registers so the strobe cycle already shows the new pulse.
  assign peak_value = peak_valid ? max_q   : held_v;
  assign peak_width = peak_valid ? width_q : held_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q   <= '0;
      width_q <= '0;
      held_v  <= '0;
      held_w  <= '0;
    end else begin
      if (arm && above && !abort) begin
        max_q   <= data;
        width_q <= 16'd1;
      end else if (track && above && !abort) begin
        if (data > max_q) max_q <= data;
        if (width_q != 16'hFFFF) width_q <= width_q + 16'd1;
      end
      if (peak_valid) begin
        held_v <= max_q;
        held_w <= width_q;
      end
    end
  end

`ifdef PILEUP_REJECT_EN
  always_ff @(posedge clk) begin
    if (reset) pileup_cnt <= '0;
    else if (fall && pileup && pileup_cnt != 16'hFFFF) pileup_cnt <= pileup_cnt + 16'd1;
  end
`endif
endmodule

// File: rtl/trap_filter_sequencer.sv
// Applies runtime k/l/M to the trapezoidal filter and gates its output behind a
// clear/settle sequence; optional PILEUP_REJECT_EN adds pileup rejection.
module trap_filter_sequencer import package_settings::*; #(
  parameter int MAX_DEPTH    = 64,
  parameter int PIPE_LAT     = trap_seq_pkg::PIPE_LAT,
  parameter int FLUSH_CYCLES = 4,
  parameter int DEF_K        = trap_seq_pkg::DEF_K,
  parameter int DEF_L        = trap_seq_pkg::DEF_L,
  parameter int DEF_M        = trap_seq_pkg::DEF_M,
  parameter int CW           = $clog2(MAX_DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  trap_filter_sequencer_if.slave             cfg,
  input  logic signed [SIZE_FILTER_DATA-1:0] thr,
  output logic                               filt_clear,
  output logic                               filt_en,
  output logic [CW-1:0]                      act_k,
  output logic [CW-1:0]                      act_l,
  output logic [15:0]                        act_m,
  input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
  output logic                               data_valid,
`ifdef PILEUP_REJECT_EN
  output logic [15:0]                        pileup_cnt,
`endif
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_value,
  output logic [15:0]                        peak_width
);
  import trap_seq_pkg::*;

  localparam int CNTW = $clog2(2 * MAX_DEPTH + PIPE_LAT + FLUSH_CYCLES + 1);

  seq_state_e      state, next;
  logic [CNTW-1:0] cnt, settle_last;
  logic            cfg_fire, cfg_good, above, abort;

  assign cfg.cfg_ready = (state == IDLE) || (state == RUN_WAIT);
  assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
  assign cfg_good      = cfg_is_valid(int'(cfg.cfg_k), int'(cfg.cfg_l), MAX_DEPTH);
  // Settle covers the full delay line plus the filter pipeline for the active config.
  assign settle_last   = CNTW'(act_k) + CNTW'(act_l) + CNTW'(PIPE_LAT - 1);

  assign filt_clear = (state == IDLE) || (state == FLUSH);
  assign filt_en    = (state != IDLE);
  assign data_valid = (state == RUN_WAIT) || (state == RUN_PULSE);
  assign abort      = !enable || (cfg_fire && cfg_good);

  always_comb begin
    next = state;
    case (state)
      IDLE:      if (enable) next = FLUSH;
      FLUSH:     if (cnt == CNTW'(FLUSH_CYCLES - 1)) next = SETTLE;
      SETTLE:    if (cnt == settle_last) next = RUN_WAIT;
      RUN_WAIT:  if (cfg_fire && cfg_good) next = FLUSH;
                 else if (above) next = RUN_PULSE;
      RUN_PULSE: if (!above) next = RUN_WAIT;
      default:   next = IDLE;
    endcase
    if (!enable) next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      if (next != state) cnt <= '0;
      else if (state == FLUSH || state == SETTLE) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_k       <= CW'(DEF_K);
      act_l       <= CW'(DEF_L);
      act_m       <= 16'(DEF_M);
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= cfg_fire && !cfg_good;
      if (cfg_fire && cfg_good) begin
        act_k <= cfg.cfg_k;
        act_l <= cfg.cfg_l;
        act_m <= cfg.cfg_m;
      end
    end
  end

`ifdef PILEUP_REJECT_EN
  logic [15:0] pileup_lim;
  assign pileup_lim = (16'(act_k) + 16'(act_l)) << 1;
`endif

  trap_peak_detector #(.DW(SIZE_FILTER_DATA)) u_peak (
    .clk        (clk),
    .reset      (reset),
    .arm        (state == RUN_WAIT),
    .track      (state == RUN_PULSE),
    .abort      (abort),
    .data       (filt_data),
    .thr        (thr),
`ifdef PILEUP_REJECT_EN
    .pileup_lim (pileup_lim),
    .pileup_cnt (pileup_cnt),
`endif
    .above      (above),
    .peak_valid (peak_valid),
    .peak_value (peak_value),
    .peak_width (peak_width)
  );
endmodule

// File: tb/tb_trap_filter_sequencer.sv
// Scoreboard bench for trap_filter_sequencer: a timeline-based reference model
// queues expected per-cycle status and peak reports; a negedge monitor checks them.
module tb_trap_filter_sequencer;
  localparam int MAX_DEPTH = 64, CW = 7, FLUSH = 4, PLAT = 6, DW = 16;
  localparam int DK = 8, DL = 16, DM = 32;
`ifdef PILEUP_REJECT_EN
  localparam bit PILE = 1'b1;
`else
  localparam bit PILE = 1'b0;
`endif

  typedef struct packed {
    logic          filt_clear, filt_en, data_valid, cfg_ready, cfg_err, peak_valid;
    logic [CW-1:0] k, l;
    logic [15:0]   m, pv, pw, pc;
  } st_t;
  typedef struct {int v; int w;} pk_t;

  logic clk = 1'b0, reset, enable;
  logic signed [DW-1:0] thr, filt_data, peak_value;
  logic filt_clear, filt_en, data_valid, peak_valid;
  logic [CW-1:0] act_k, act_l;
  logic [15:0] act_m, peak_width, pc_act;
`ifdef PILEUP_REJECT_EN
  logic [15:0] pileup_cnt;
  assign pc_act = pileup_cnt;
`else
  assign pc_act = 16'd0;
`endif

  trap_filter_sequencer_if #(.CW(CW)) cfg();

  trap_filter_sequencer #(.MAX_DEPTH(MAX_DEPTH), .PIPE_LAT(PLAT), .FLUSH_CYCLES(FLUSH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg(cfg), .thr(thr),
    .filt_clear(filt_clear), .filt_en(filt_en),
    .act_k(act_k), .act_l(act_l), .act_m(act_m),
    .filt_data(filt_data), .data_valid(data_valid),
`ifdef PILEUP_REJECT_EN
    .pileup_cnt(pileup_cnt),
`endif
    .peak_valid(peak_valid), .peak_value(peak_value), .peak_width(peak_width)
  );

  always #5 clk = ~clk;

  st_t exp_q[$];
  pk_t pk_q[$];
  int  checks = 0, errors = 0;

  // Reference model: a flush start time plus the list of above-threshold samples.
  int cyc = 0, m_start, mk, ml, mm, held_v, held_w, pile;
  bit err_q;
  int pulse[$];

  task automatic model_reset();
    m_start = -1; mk = DK; ml = DL; mm = DM;
    held_v = 0; held_w = 0; pile = 0; err_q = 1'b0;
    pulse.delete();
  endtask

  task automatic step(input bit rst, input bit en, input bit cv,
                      input int k, input int l, input int m, input int th, input int d);
    st_t e;
    bit  idle, run, ready, above, fall, strobe, hit, accept, ok;
    int  t, mx, w;
    @(posedge clk); #1;
    reset = rst; enable = en; cfg.cfg_valid = cv;
    cfg.cfg_k = CW'(k); cfg.cfg_l = CW'(l); cfg.cfg_m = 16'(m);
    thr = DW'(th); filt_data = DW'(d);

    idle  = m_start < 0;
    t     = cyc - m_start;
    run   = !idle && t >= FLUSH + mk + ml + PLAT;
    ready = idle || (run && pulse.size() == 0);
    above = d > th;
    fall  = run && pulse.size() > 0 && !above && en;
    mx = 0;
    if (pulse.size() > 0) begin
      mx = pulse[0];
      foreach (pulse[i]) if (pulse[i] > mx) mx = pulse[i];
    end
    w      = pulse.size() > 65535 ? 65535 : pulse.size();
    hit    = PILE && w >= 2 * (mk + ml);
    strobe = fall && !hit;

    e.filt_clear = idle || t < FLUSH;
    e.filt_en    = !idle;
    e.data_valid = run;
    e.cfg_ready  = ready;
    e.cfg_err    = err_q;
    e.peak_valid = strobe;
    e.k = CW'(mk); e.l = CW'(ml); e.m = 16'(mm);
    e.pv = strobe ? 16'(mx) : 16'(held_v);
    e.pw = strobe ? 16'(w)  : 16'(held_w);
    e.pc = 16'(pile);
    exp_q.push_back(e);
    if (strobe) pk_q.push_back('{mx, w});

    if (rst) model_reset();
    else begin
      accept = cv && ready;
      ok     = k >= 1 && l >= k && k + l <= MAX_DEPTH;
      err_q  = accept && !ok;
      if (strobe) begin held_v = mx; held_w = w; end
      if (fall && hit && pile < 65535) pile++;
      if (!en) begin
        m_start = -1; pulse.delete();
      end else if (idle) m_start = cyc + 1;
      else if (run) begin
        if (accept && ok) begin m_start = cyc + 1; pulse.delete(); end
        else if (above) pulse.push_back(d);
        else pulse.delete();
      end
      if (accept && ok) begin mk = k; ml = l; mm = m; end
    end
    cyc++;
  endtask

  task automatic run_n(input int n, input bit en, input int th, input int d);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0, 0, th, d);
  endtask

  // Monitor: status every cycle, plus a peak record whenever the DUT strobes.
  always @(negedge clk) begin
    st_t a, e;
    pk_t p;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{filt_clear, filt_en, data_valid, cfg.cfg_ready, cfg.cfg_err, peak_valid,
            act_k, act_l, act_m, peak_value, peak_width, pc_act};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL status t=%0t actual=%h expected=%h", $time, a, e);
      end
    end
    if (peak_valid === 1'b1) begin
      checks++;
      if (pk_q.size() == 0) begin
        errors++;
        $display("FAIL peak t=%0t unexpected report value=%0d width=%0d", $time, peak_value, peak_width);
      end else begin
        p = pk_q.pop_front();
        if (int'(peak_value) != p.v || int'(peak_width) != p.w) begin
          errors++;
          $display("FAIL peak t=%0t actual=%0d/%0d expected=%0d/%0d",
                   $time, peak_value, peak_width, p.v, p.w);
        end
      end
    end
  end

  initial begin
    int seq[5] = '{0, 60, 120, 90, 40};
    int th, k, l, d;
    bit hi;
    reset = 1'b1; enable = 1'b0; cfg.cfg_valid = 1'b0;
    cfg.cfg_k = '0; cfg.cfg_l = '0; cfg.cfg_m = '0; thr = '0; filt_data = '0;
    model_reset();

    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 0, 50, 0);
    run_n(40, 1'b1, 50, 0);                                // default settle
    step(1'b0, 1'b1, 1'b1, 4, 8, 100, 50, 0);  run_n(25, 1'b1, 50, 0);
    step(1'b0, 1'b1, 1'b1, 10, 5, 7, 50, 0);   run_n(3, 1'b1, 50, 0);
    step(1'b0, 1'b1, 1'b1, 32, 33, 7, 50, 0);  run_n(3, 1'b1, 50, 0);
    step(1'b0, 1'b1, 1'b1, 0, 0, 7, 50, 0);    run_n(3, 1'b1, 50, 0);
    step(1'b0, 1'b1, 1'b1, 32, 32, 9, 50, 0);  run_n(80, 1'b1, 50, 0);
    step(1'b0, 1'b1, 1'b1, 4, 8, 100, 50, 0);  run_n(25, 1'b1, 50, 0);
    foreach (seq[i]) step(1'b0, 1'b1, 1'b0, 0, 0, 0, 50, seq[i]);
    run_n(3, 1'b1, 50, 0);
    run_n(2, 1'b1, 50, 200);
    run_n(3, 1'b0, 50, 200);                               // pulse discarded
    step(1'b0, 1'b0, 1'b1, 3, 5, 11, 50, 0);   run_n(2, 1'b0, 50, 0);
    step(1'b0, 1'b1, 1'b1, 4, 8, 100, 50, 0);  run_n(25, 1'b1, 50, 0);
    run_n(30, 1'b1, 50, 200);                              // long pulse
    run_n(3, 1'b1, 50, 0);
    run_n(10, 1'b1, 50, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 50, 0);    run_n(5, 1'b1, 50, 0);

    th = 0; hi = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) th = int'($urandom_range(200)) - 100;
      if ($urandom_range(7) == 0) hi = !hi;
      k = int'($urandom_range(40));
      l = int'($urandom_range(40));
      d = hi ? th + 1 + int'($urandom_range(199)) : th - int'($urandom_range(200));
      step($urandom_range(999) == 0, $urandom_range(999) >= 3, $urandom_range(59) == 0,
           k, l, int'($urandom_range(65535)), th, d);
    end
    run_n(2, 1'b0, 0, 0);
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (pk_q.size() != 0) begin
      errors++;
      $display("FAIL peak_drain actual=%0d pending expected=0", pk_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
